xbar_frame_sequencer: RTL
=========================

# xbar_frame_sequencer

Frame/slot sequencer for the crossbar input stage. It generates the symbol strobe (`clk10`), slot index, header/payload phase and bank select that steer deserialized symbols into the double-buffered input memory. It also sweeps `mux_sel` across the idle bank so the downstream switch stage reads every port/slot entry under a valid/ready handshake. It sits between the system control and the input memory, one instance per crossbar.

## Interface
Parameters:
- `PORTS`, 8: number of input ports; `mux_sel[4:2]` selects the port.
- `SLOTS`, 4: slots per phase; `running_slot` and `mux_sel[1:0]` select the slot.
- `DIV`, 10: clock cycles per deserialized symbol (8b/10b).

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; enables frame sequencing.
- `clk10`  out  1  symbol strobe, one-cycle pulse every `DIV` cycles.
- `running_slot`  out  2  slot being written.
- `header_present`  out  1  0 = header phase, 1 = payload phase.
- `bank_sel`  out  1  bank being written; the read side uses `!bank_sel`.
- `mux_sel`  out  5  read index {port[2:0], slot[1:0]}.
- `rd_valid`  in/out: out  1  `mux_sel` is a valid read entry.
- `rd_ready`  in  1  downstream accepts the current entry.
- `frame_done`  out  1  one-cycle pulse on each bank swap.
- `overrun`  out  1  sticky; bank swapped before the read sweep completed.

## Operation
- Write FSM states:
  - IDLE, HDR, PAY.
  - IDLE -> HDR when `run`=1; this also clears `div_cnt`.
  - HDR -> PAY on the strobe with `running_slot`=SLOTS-1.
  - PAY -> HDR on the strobe with `running_slot`=SLOTS-1, or PAY -> IDLE on that same strobe if `run`=0.
- `run` is only sampled at the IDLE exit and at the frame boundary. Deasserting it mid-frame completes the current frame.
- `div_cnt` counts 0..DIV-1 in HDR/PAY and holds at 0 in IDLE. `clk10` = (`div_cnt`==DIV-1) and not IDLE.
- `running_slot` increments on each strobe and wraps SLOTS-1 -> 0 at every phase change.
- `header_present` is 0 in HDR and 1 in PAY.
- Frame boundary is the strobe in PAY with slot SLOTS-1. At that edge:
  - `bank_sel` toggles.
  - `frame_done` pulses for one cycle.
  - The read sweep (re)starts.
- Read sweep:
  - `rd_valid`=1 and `mux_sel`=0 from the cycle after the boundary.
  - `mux_sel` increments on each cycle with `rd_valid` && `rd_ready`.
  - After the accept at `mux_sel`=PORTS*SLOTS-1 (31), `rd_valid`=0 and `mux_sel` holds at 0.
  - `mux_sel` never changes while `rd_valid`=1 && `rd_ready`=0.
- Overrun: a boundary that arrives while `rd_valid`=1 sets `overrun`, and the sweep restarts at 0 on the new bank. The boundary has priority over a simultaneous accept.

## Timing
- Reset values:
  - State IDLE, `div_cnt`=0, `clk10`=0, `running_slot`=0.
  - `header_present`=0, `bank_sel`=0, `mux_sel`=0.
  - `rd_valid`=0, `frame_done`=0, `overrun`=0.
- `rst` mid-frame returns to these values on the next edge and discards the read sweep.
- The first strobe occurs DIV cycles after the IDLE->HDR edge.
- Slot, phase and bank outputs update on the strobe edge. The memory samples them in the strobe cycle, before the update.
- A frame is 2*SLOTS*DIV = 80 cycles. With `rd_ready` held high a sweep takes 32 cycles, so no overrun occurs.
- `frame_done` and the start of `rd_valid` are separated by one cycle.

## Configuration
- `XBAR_SEQ_OVERRUN_EN` defined:
  - `overrun` is a sticky flag, cleared only by `rst`.
  - An internal 8-bit saturating overrun counter is kept for debug.
- Not defined:
  - `overrun` is tied to 0 and the counter is absent.
  - Sweep restart on the boundary still occurs.

## Test plan
- Reset, then `run`=1 with `rd_ready`=1:
  - `clk10` pulses at cycles 10, 20, …
  - Slots 0,1,2,3 with `header_present`=0, then 0..3 with 1.
  - `bank_sel` 0->1 at cycle 80 with `frame_done`=1.
  - `mux_sel` 0..31 over cycles 81-112, then `rd_valid`=0.
- Back-pressure: `rd_ready` toggled 1/0 each cycle → each `mux_sel` value is held two cycles, and all 32 entries are presented in order.
- Overrun: `rd_ready`=0 for a whole frame → at the second boundary `overrun`=1 and `mux_sel` restarts at 0 with `bank_sel`=0. With the macro off, `overrun` stays 0.
- `run` deasserted at cycle 45 → the frame completes, then IDLE after the cycle-80 boundary: `clk10` stays 0 and `bank_sel`=1 holds.
- `rst` asserted at cycle 50 mid-payload → all outputs return to reset values the next cycle, and restart timing matches the first scenario.

Source files
------------

// File: rtl/xbar_frame_sequencer.sv
// Frame/slot sequencer for the crossbar input stage: symbol strobe, slot/phase/bank steering and idle-bank read sweep.
// Define XBAR_SEQ_OVERRUN_EN to enable the sticky overrun flag and its 8-bit saturating debug counter.
module xbar_frame_sequencer #(
    parameter int PORTS = 8,
    parameter int SLOTS = 4,
    parameter int DIV   = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run,
    output logic                             clk10,
    output logic [$clog2(SLOTS)-1:0]         running_slot,
    output logic                             header_present,
    output logic                             bank_sel,
    output logic [$clog2(PORTS*SLOTS)-1:0]   mux_sel,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic                             frame_done,
    output logic                             overrun
);

    localparam int SW = $clog2(SLOTS);
    localparam int MW = $clog2(PORTS*SLOTS);
    localparam int DW = $clog2(DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] div_cnt;
    logic          slot_last;
    logic          phase_end;
    logic          boundary;
    logic          sweep_last;

    // Strobe and boundary are decoded from registered state, so they are
    // high in the cycle the memory samples the current slot/phase/bank.
    assign clk10          = (div_cnt == DW'(DIV-1)) && (state != IDLE);
    assign slot_last      = (running_slot == SW'(SLOTS-1));
    assign phase_end      = clk10 && slot_last;
    assign boundary       = phase_end && (state == PAY);
    assign frame_done     = boundary;
    assign header_present = (state == PAY);
    assign sweep_last     = (mux_sel == MW'(PORTS*SLOTS-1));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (run)       state_nxt = HDR;
            HDR:     if (phase_end) state_nxt = PAY;
            PAY:     if (phase_end) state_nxt = run ? HDR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            running_slot <= '0;
            bank_sel     <= 1'b0;
        end else begin
            if (state == IDLE || clk10) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            if (clk10) begin
                running_slot <= slot_last ? '0 : running_slot + SW'(1);
            end
            if (boundary) begin
                bank_sel <= ~bank_sel;
            end
        end
    end

    // A boundary restarts the sweep on the new idle bank even if an accept lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            mux_sel  <= '0;
        end else if (boundary) begin
            rd_valid <= 1'b1;
            mux_sel  <= '0;
        end else if (rd_valid && rd_ready) begin
            if (sweep_last) begin
                rd_valid <= 1'b0;
                mux_sel  <= '0;
            end else begin
                mux_sel  <= mux_sel + MW'(1);
            end
        end
    end

`ifdef XBAR_SEQ_OVERRUN_EN
    logic [7:0] overrun_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt <= 8'd0;
        end else if (boundary && rd_valid && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    assign overrun = (overrun_cnt != 8'd0);
`else
    assign overrun = 1'b0;
`endif

endmodule
